// File: rtl/video_pattern_generator.sv
// Test-pattern source feeding the HDMI source stage: 4 pixels per beat over ready/valid,
// framed by start_frame, with colour bars, ramp, moving checkerboard and solid colour.
module video_pattern_generator #(
   parameter int CHECKER_SHIFT = 5,
   parameter int RAMP_SHIFT    = 0
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [15:0] i_video_width,
   input  logic [15:0] i_video_height,
   input  logic [1:0]  i_pattern_select,
   input  logic [23:0] i_solid_colour,
   input  logic        i_start_frame,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [63:0] o_bits_0,
   output logic [63:0] o_bits_1,
   output logic [63:0] o_bits_2,
   output logic [63:0] o_bits_3,
   output logic [7:0]  o_frame_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic              r_rst_meta, r_rst_sync;
   logic [1:0]        r_state, w_state_next;
   logic [15:0]       r_x, r_y, r_width, r_height;
   logic [15:0]       w_x_next, w_y_next;
   logic [1:0]        r_pattern, w_cfg_pattern;
   logic [23:0]       r_solid, w_cfg_solid;
   logic [15:0]       r_thr [1:7];
   logic [15:0]       w_thr_in [1:7];
   logic [15:0]       w_thr_eff [1:7];
   logic [7:0]        r_frame_count, r_fc_frame, w_fc_next, w_fc_eff;
   logic              r_valid, w_valid_next, w_load;
   logic              w_xfer, w_eol, w_last, w_size_zero;
   logic [3:0][63:0]  r_bits, w_beat;

   // Asserts asynchronously, releases two clocks after i_reset_n rises.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   function automatic logic [23:0] f_bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    f_bar_colour = 24'hFFFFFF;
         3'd1:    f_bar_colour = 24'hFFFF00;
         3'd2:    f_bar_colour = 24'h00FFFF;
         3'd3:    f_bar_colour = 24'h00FF00;
         3'd4:    f_bar_colour = 24'hFF00FF;
         3'd5:    f_bar_colour = 24'hFF0000;
         3'd6:    f_bar_colour = 24'h0000FF;
         default: f_bar_colour = 24'h000000;
      endcase
   endfunction

   // Bar thresholds (width*i)>>3 built from shifted copies of the width, no multiplier.
   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_thr
         localparam int M = gi;
         logic [18:0] w_mul;
         assign w_mul = (((M & 1) != 0) ? {3'b000, i_video_width}       : 19'd0)
                      + (((M & 2) != 0) ? {2'b00, i_video_width, 1'b0}  : 19'd0)
                      + (((M & 4) != 0) ? {1'b0, i_video_width, 2'b00}  : 19'd0);
         assign w_thr_in[gi]  = 16'(w_mul >> 3);
         assign w_thr_eff[gi] = i_start_frame ? w_thr_in[gi] : r_thr[gi];
      end
   endgenerate

   assign w_cfg_pattern = i_start_frame ? i_pattern_select : r_pattern;
   assign w_cfg_solid   = i_start_frame ? i_solid_colour   : r_solid;
   assign w_size_zero   = (i_video_width == 16'd0) || (i_video_height == 16'd0);

   assign w_xfer    = r_valid & i_ready;
   assign w_eol     = (r_x == r_width - 16'd4);
   assign w_last    = w_xfer & w_eol & (r_y == r_height - 16'd1);
   assign w_fc_next = r_frame_count + {7'd0, w_last};
   assign w_fc_eff  = i_start_frame ? w_fc_next : r_fc_frame;

   // Pixels of the beat that will be on the outputs next cycle.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pix
         logic [15:0] w_px;
         logic [2:0]  w_bar;
         logic [7:0]  w_ramp;
         logic        w_white;
         logic [23:0] w_rgb;

         assign w_px    = w_x_next + 16'(gi);
         assign w_ramp  = 8'(w_px >> RAMP_SHIFT);
         assign w_white = (((((w_px + {8'h00, w_fc_eff}) >> CHECKER_SHIFT)
                           ^ (w_y_next >> CHECKER_SHIFT)) & 16'd1) != 16'd0);

         always_comb begin
            w_bar = 3'd0;
            for (int i = 1; i < 8; i++) begin
               if (w_thr_eff[i] <= w_px) w_bar = w_bar + 3'd1;
            end
         end

         always_comb begin
            w_rgb = 24'h000000;
            case (w_cfg_pattern)
               2'd0:    w_rgb = f_bar_colour(w_bar);
               2'd1:    w_rgb = {w_ramp, w_ramp, w_ramp};
               2'd2:    w_rgb = w_white ? 24'hFFFFFF : 24'h000000;
               default: w_rgb = w_cfg_solid;
            endcase
         end

         assign w_beat[gi] = {16'h0000, w_rgb[23:16], 8'h00, w_rgb[15:8], 8'h00, w_rgb[7:0], 8'h00};
      end
   endgenerate

   always_ff @(posedge i_clock or negedge r_rst_sync) begin
      if (!r_rst_sync) r_state <= S_IDLE;
      else             r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (i_start_frame)                 w_state_next = w_size_zero ? S_IDLE : S_RUN;
      else if (r_state == S_RUN && w_last) w_state_next = S_DONE;
   end

   always_comb begin
      w_x_next     = r_x;
      w_y_next     = r_y;
      w_valid_next = r_valid;
      w_load       = 1'b0;
      if (i_start_frame) begin
         w_x_next     = 16'd0;
         w_y_next     = 16'd0;
         w_valid_next = !w_size_zero;
         w_load       = 1'b1;
      end else if (w_xfer) begin
         if (w_eol) begin
            w_x_next = 16'd0;
            w_y_next = r_y + 16'd1;
         end else begin
            w_x_next = r_x + 16'd4;
         end
         w_valid_next = !w_last;
         w_load       = !w_last;
      end
   end

   always_ff @(posedge i_clock or negedge r_rst_sync) begin
      if (!r_rst_sync) begin
         r_x           <= 16'd0;
         r_y           <= 16'd0;
         r_width       <= 16'd0;
         r_height      <= 16'd0;
         r_pattern     <= 2'd0;
         r_solid       <= 24'd0;
         r_valid       <= 1'b0;
         r_bits        <= '0;
         r_frame_count <= 8'd0;
         r_fc_frame    <= 8'd0;
         for (int i = 1; i < 8; i++) r_thr[i] <= 16'd0;
      end else begin
         r_x           <= w_x_next;
         r_y           <= w_y_next;
         r_valid       <= w_valid_next;
         r_frame_count <= w_fc_next;
         if (i_start_frame) begin
            r_width    <= i_video_width;
            r_height   <= i_video_height;
            r_pattern  <= i_pattern_select;
            r_solid    <= i_solid_colour;
            r_fc_frame <= w_fc_eff;
            for (int i = 1; i < 8; i++) r_thr[i] <= w_thr_in[i];
         end
         if (w_load) r_bits <= w_beat;
      end
   end

   assign o_valid       = r_valid;
   assign o_bits_0      = r_bits[0];
   assign o_bits_1      = r_bits[1];
   assign o_bits_2      = r_bits[2];
   assign o_bits_3      = r_bits[3];
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Directed bench for video_pattern_generator: bars, backpressure, ramp, solid,
// checkerboard motion, frame restarts and asynchronous reset.
module tb_video_pattern_generator;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic [15:0] i_video_width, i_video_height;
   logic [1:0]  i_pattern_select;
   logic [23:0] i_solid_colour;
   logic        i_start_frame, i_ready;
   logic        o_valid;
   logic [63:0] o_bits_0, o_bits_1, o_bits_2, o_bits_3;
   logic [7:0]  o_frame_count;
   logic [255:0] beat_now;

   int checks = 0;
   int errors = 0;
   logic [255:0] q[$];
   logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   always #5 clk = ~clk;
   assign beat_now = {o_bits_3, o_bits_2, o_bits_1, o_bits_0};

   video_pattern_generator #(.CHECKER_SHIFT(5), .RAMP_SHIFT(0)) dut (
      .i_clock(clk), .i_reset_n(i_reset_n),
      .i_video_width(i_video_width), .i_video_height(i_video_height),
      .i_pattern_select(i_pattern_select), .i_solid_colour(i_solid_colour),
      .i_start_frame(i_start_frame), .i_ready(i_ready),
      .o_valid(o_valid), .o_bits_0(o_bits_0), .o_bits_1(o_bits_1),
      .o_bits_2(o_bits_2), .o_bits_3(o_bits_3), .o_frame_count(o_frame_count)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pix(input logic [23:0] rgb);
      return {16'h0000, rgb[23:16], 8'h00, rgb[15:8], 8'h00, rgb[7:0], 8'h00};
   endfunction

   function automatic logic [255:0] beat4(input logic [23:0] c0, c1, c2, c3);
      return {pix(c3), pix(c2), pix(c1), pix(c0)};
   endfunction

   // width 16: thresholds 2,4,..,14, so each bar is two pixels wide
   function automatic logic [255:0] bars_beat(input int n);
      int b;
      b = n % 4;
      return beat4(bar_tab[(b*4+0)/2], bar_tab[(b*4+1)/2], bar_tab[(b*4+2)/2], bar_tab[(b*4+3)/2]);
   endfunction

   // called at a negedge; returns at the negedge where the first beat is visible
   task automatic start(input logic [1:0] pat, input logic [15:0] w, input logic [15:0] h,
                        input logic [23:0] solid);
      i_pattern_select = pat;
      i_video_width    = w;
      i_video_height   = h;
      i_solid_colour   = solid;
      i_start_frame    = 1'b1;
      @(negedge clk);
      i_start_frame    = 1'b0;
      i_pattern_select = ~pat;
      i_video_width    = 16'd4;
      i_video_height   = 16'd1;
      i_solid_colour   = 24'h5A5A5A;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
   task automatic collect(input int mode, input int max_cyc);
      logic [255:0] held;
      bit hold;
      hold = 1'b0;
      held = '0;
      q.delete();
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         if (!o_valid) break;
         if (hold) chk("hold_stable", beat_now, held);
         i_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (i_ready) q.push_back(beat_now);
         hold = !i_ready;
         held = beat_now;
         @(negedge clk);
      end
      i_ready = 1'b1;
      chk("frame_end_in_time", {255'd0, o_valid}, 256'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset_n = 1'b0;
      i_video_width = 16'd0;
      i_video_height = 16'd0;
      i_pattern_select = 2'd0;
      i_solid_colour = 24'd0;
      i_start_frame = 1'b0;
      i_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_valid", {255'd0, o_valid}, 256'd0);
      chk("reset_bits", beat_now, 256'd0);
      chk("reset_fc", {248'd0, o_frame_count}, 256'd0);
      i_reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_valid", {255'd0, o_valid}, 256'd0);

      // 1: colour bars, 16x2
      start(2'd0, 16'd16, 16'd2, 24'd0);
      chk("t1_valid", {255'd0, o_valid}, 256'd1);
      chk("t1_first_beat", beat_now,
          beat4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00));
      collect(0, 50);
      chk("t1_count", 256'(q.size()), 256'd8);
      for (int n = 0; n < 8; n++) chk($sformatf("t1_beat%0d", n), q[n], bars_beat(n));
      chk("t1_fc", {248'd0, o_frame_count}, 256'd1);

      // 2: backpressure
      start(2'd0, 16'd16, 16'd2, 24'd0);
      collect(1, 100);
      chk("t2_count", 256'(q.size()), 256'd8);
      for (int n = 0; n < 8; n++) chk($sformatf("t2_beat%0d", n), q[n], bars_beat(n));
      chk("t2_fc", {248'd0, o_frame_count}, 256'd2);

      // 3: ramp, 256x1
      start(2'd1, 16'd256, 16'd1, 24'd0);
      collect(0, 200);
      chk("t3_count", 256'(q.size()), 256'd64);
      for (int n = 0; n < 64; n++) begin
         logic [7:0] v0, v1, v2, v3;
         v0 = 8'(4*n); v1 = 8'(4*n+1); v2 = 8'(4*n+2); v3 = 8'(4*n+3);
         chk($sformatf("t3_beat%0d", n), q[n],
             beat4({v0, v0, v0}, {v1, v1, v1}, {v2, v2, v2}, {v3, v3, v3}));
      end
      chk("t3_fc", {248'd0, o_frame_count}, 256'd3);
      repeat (3) @(negedge clk);
      chk("t3_done_quiet", {255'd0, o_valid}, 256'd0);

      // solid, 8x1
      start(2'd3, 16'd8, 16'd1, 24'h123456);
      collect(0, 20);
      chk("solid_count", 256'(q.size()), 256'd2);
      chk("solid_beat0", q[0], beat4(24'h123456, 24'h123456, 24'h123456, 24'h123456));
      chk("solid_beat1", q[1], beat4(24'h123456, 24'h123456, 24'h123456, 24'h123456));
      chk("solid_fc", {248'd0, o_frame_count}, 256'd4);

      // clear frame_count before the checkerboard frames
      i_reset_n = 1'b0;
      @(negedge clk);
      chk("rst2_fc", {248'd0, o_frame_count}, 256'd0);
      i_reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // 4: checkerboard, 64x64, three frames
      for (int f = 0; f < 3; f++) begin
         start(2'd2, 16'd64, 16'd64, 24'd0);
         collect(0, 1100);
         chk($sformatf("t4_f%0d_count", f), 256'(q.size()), 256'd1024);
         if (f == 0) begin
            chk("t4_f0_x32", {192'd0, q[8][63:0]}, {192'd0, pix(24'hFFFFFF)});
            chk("t4_f0_x31", {192'd0, q[7][255:192]}, {192'd0, pix(24'h000000)});
            chk("t4_f0_x0_y32", {192'd0, q[512][63:0]}, {192'd0, pix(24'hFFFFFF)});
         end else if (f == 1) begin
            chk("t4_f1_x31", {192'd0, q[7][255:192]}, {192'd0, pix(24'hFFFFFF)});
            chk("t4_f1_x30", {192'd0, q[7][191:128]}, {192'd0, pix(24'h000000)});
         end else begin
            chk("t4_f2_x30", {192'd0, q[7][191:128]}, {192'd0, pix(24'hFFFFFF)});
         end
      end
      chk("t4_fc", {248'd0, o_frame_count}, 256'd3);

      // 5a: restart mid-frame at beat 3
      start(2'd0, 16'd16, 16'd2, 24'd0);
      repeat (3) @(negedge clk);
      chk("t5a_at_beat3", beat_now, bars_beat(3));
      start(2'd0, 16'd16, 16'd2, 24'd0);
      chk("t5a_restart_beat", beat_now, bars_beat(0));
      chk("t5a_fc_same", {248'd0, o_frame_count}, 256'd3);
      collect(0, 50);
      chk("t5a_count", 256'(q.size()), 256'd8);
      chk("t5a_fc_end", {248'd0, o_frame_count}, 256'd4);

      // 5b: restart coincident with the last transfer
      start(2'd0, 16'd16, 16'd2, 24'd0);
      repeat (7) @(negedge clk);
      chk("t5b_at_beat7", beat_now, bars_beat(7));
      chk("t5b_fc_before", {248'd0, o_frame_count}, 256'd4);
      start(2'd0, 16'd16, 16'd2, 24'd0);
      chk("t5b_valid", {255'd0, o_valid}, 256'd1);
      chk("t5b_restart_beat", beat_now, bars_beat(0));
      chk("t5b_fc_inc", {248'd0, o_frame_count}, 256'd5);
      collect(0, 50);
      chk("t5b_count", 256'(q.size()), 256'd8);
      chk("t5b_fc_end", {248'd0, o_frame_count}, 256'd6);

      // 6: asynchronous reset mid-frame
      start(2'd0, 16'd16, 16'd2, 24'd0);
      repeat (2) @(negedge clk);
      #2 i_reset_n = 1'b0;
      #1;
      chk("t6_async_valid", {255'd0, o_valid}, 256'd0);
      chk("t6_async_bits", beat_now, 256'd0);
      chk("t6_async_fc", {248'd0, o_frame_count}, 256'd0);
      @(negedge clk);
      #2 i_reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("t6_quiet%0d", c), {255'd0, o_valid}, 256'd0);
      end
      start(2'd0, 16'd16, 16'd2, 24'd0);
      chk("t6_restart_valid", {255'd0, o_valid}, 256'd1);
      chk("t6_restart_beat", beat_now, bars_beat(0));
      collect(0, 50);
      chk("t6_count", 256'(q.size()), 256'd8);
      chk("t6_fc", {248'd0, o_frame_count}, 256'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_pattern_generator.md
Name: video_pattern_generator

Overview:
Synthesisable test-pattern source that sits directly upstream of the HDMI source stage in the tx clock domain. It supplies 4 pixels per beat over a ready/valid stream, framed by the source's start_frame pulse. It provides colour bars, a horizontal ramp, a moving checkerboard and a solid colour, which gives a deterministic picture for link bring-up at any supported resolution.

Parameters:
CHECKER_SHIFT, 5, log2 of the checkerboard square size in pixels (default 32x32).
RAMP_SHIFT, 0, right-shift applied to pixel x before the ramp value is taken.

Ports:
clock  input  1  tx clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
video_width  input  16  active pixels per line; must be a non-zero multiple of 4
video_height  input  16  active lines per frame; must be non-zero
pattern_select  input  2  0 = colour bars, 1 = ramp, 2 = checkerboard, 3 = solid
solid_colour  input  24  {R,G,B}, 8 bits each; used when pattern_select = 3
start_frame  input  1  one-cycle pulse from the HDMI source at start of frame
ready  input  1  downstream accepts a beat
valid  output  1  beat available
bits_0..bits_3  output  64 each  pixel k of the beat; [63:48]=0, [47:32]={R,8'h00}, [31:16]={G,8'h00}, [15:0]={B,8'h00}
frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (reset low, asynchronous): valid=0, bits_*=0, frame_count=0, x=0, y=0, state=IDLE.
- Reset is released synchronously internally; assertion in mid-frame aborts the frame immediately.
- States:
  - IDLE: waits for start_frame.
  - RUN: streams beats.
  - DONE: frame finished, waits for start_frame.
- start_frame in any state:
  - Latch pattern_select, solid_colour, video_width and video_height.
  - Compute bar thresholds t_i=(width*i)>>3 for i=1..7 using shifts and adds (no divider).
  - Set x=0, y=0, enter RUN.
  - If the latched width or height is 0, go to IDLE instead.
- Latency: valid rises on the cycle after start_frame, with beat (x=0,y=0) already on bits_*.
- Outputs are registered.
- While valid=1 and ready=0: bits_* and valid hold stable.
- Transfer = valid & ready.
  - On a transfer, x += 4.
  - If x == width-4: x=0 and y += 1.
  - If additionally y == height-1: go to DONE, valid=0 next cycle, frame_count += 1 (8-bit wrap).
- start_frame coinciding with a transfer: start_frame wins. The next beat is (0,0). frame_count increments only if that transfer was the frame's last beat.
- start_frame while in RUN mid-frame: the frame restarts at (0,0); frame_count unchanged.
- Pixel k of a beat has pixel_x = x+k.
- Colour bars: bar index = number of thresholds t_i <= pixel_x (0..7).
  - Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Ramp: R=G=B=(pixel_x>>RAMP_SHIFT)[7:0].
- Checkerboard: px=pixel_x+frame_count (16-bit wrap).
  - Colour is white when ((px>>CHECKER_SHIFT) ^ (y>>CHECKER_SHIFT)) bit 0 = 1, else black.
  - frame_count is sampled at start_frame and is constant across the frame.
- Solid: every pixel = latched solid_colour.
- Changes to pattern_select or video_width mid-frame have no effect until the next start_frame.
- The next beat's pixels are computed combinationally from next-state x/y and registered on update, so no bubbles occur with ready held high.

Test Plan:
1. Colour bars, width=16, height=2, ready=1, pulse start_frame.
   - First beat: R/G/B bytes FF/FF/FF, FF/FF/FF, FF/FF/00, FF/FF/00.
   - Exactly 8 beats are sent, then valid=0 and frame_count=1.
2. Backpressure, same setup, ready toggled 1,0,0,1 per cycle.
   - bits_* stay stable while ready=0.
   - Beat order is unchanged and the total is still 8 beats.
3. Ramp, width=256, height=1.
   - Beat n carries R=G=B = 4n, 4n+1, 4n+2, 4n+3.
   - 64 beats are sent, then DONE.
4. Checkerboard, width=64, height=64, three frames.
   - Frame 0, pixel (32,0) is white.
   - Frame 1: square edges shift left by 1 pixel, so pixel (31,0) is white.
   - frame_count=3 at the end.
5. start_frame asserted mid-frame at beat 3 of 8, and again coincident with the last transfer.
   - In both cases the next beat is (0,0).
   - frame_count increments only in the second case.
6. Assert reset low mid-frame, asynchronously between clock edges.
   - valid and bits_* go to 0 immediately.
   - After release, no beats are produced until start_frame.
